// File: rtl/mem_ctrler.sv
// -----------------------------------------------------------------------------
// mem_ctrler
//   Serialises the two memory clients (instruction fetcher and load/store
//   buffer) onto the byte-wide unified RAM/IO port. Fetches are served as whole
//   cache-line refills; the LSB is served byte/half/word reads and writes. One
//   byte moves per cycle. The LSB has priority. Writes into the IO region
//   (mem_a[17:16] == 2'b11) are held off while io_buffer_full is high.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rdy                        global enable; low freezes every register
//   mem_din / mem_dout         RAM read data (1-cycle latency) / write data
//   mem_a / mem_wr             RAM byte address / write strobe
//   io_buffer_full             IO output buffer full (stalls IO writes)
//   *_inst_fetcher             line refill request / one-cycle ready + line
//   *_lsb                      load/store request / one-cycle ready + data
//   reset_from_rob_bus         pipeline flush (aborts LSB reads only)
// -----------------------------------------------------------------------------
module mem_ctrler #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    valid_from_inst_fetcher,
    input  logic [ADDR_WIDTH-1:0]   addr_from_inst_fetcher,
    output logic                    ready_to_inst_fetcher,
    output logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher,
    input  logic                    valid_from_lsb,
    input  logic                    is_write_from_lsb,
    input  logic [ADDR_WIDTH-1:0]   addr_from_lsb,
    input  logic [1:0]              size_from_lsb,
    input  logic [31:0]             data_from_lsb,
    output logic                    ready_to_lsb,
    output logic [31:0]             data_to_lsb,
    input  logic                    reset_from_rob_bus
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    // Counter must reach LINE_BYTES (one past the last address) and also 4.
    localparam int CW    = OFF_W + 3;
    localparam int LW    = LINE_BYTES * 8;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [CW-1:0]         LINE_LEN  = CW'(LINE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Transfer length in bytes for an LSB access size code.
    function automatic logic [CW-1:0] size_to_len(input logic [1:0] size);
        logic [CW-1:0] len;
        case (size)
            2'd0:    len = CW'(1);
            2'd1:    len = CW'(2);
            default: len = CW'(4);
        endcase
        return len;
    endfunction

    // Byte address base + k.
    function automatic logic [ADDR_WIDTH-1:0] addr_plus(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [CW-1:0]         k);
        return base + {{(ADDR_WIDTH-CW){1'b0}}, k};
    endfunction

    // Byte k (0..3) of a little-endian word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

    state_t                  state_r,      state_s;
    logic [CW-1:0]           cnt_r,        cnt_s;
    logic [CW-1:0]           len_r,        len_s;
    logic [ADDR_WIDTH-1:0]   base_r,       base_s;
    logic                    lsb_own_r,    lsb_own_s;
    logic [31:0]             wdata_r,      wdata_s;
    logic [LW-1:0]           line_r,       line_s;
    logic [ADDR_WIDTH-1:0]   mem_a_r,      mem_a_s;
    logic [7:0]              mem_dout_r,   mem_dout_s;
    logic                    mem_wr_r,     mem_wr_s;
    logic                    ready_if_r,   ready_if_s;
    logic                    ready_lsb_r,  ready_lsb_s;
    logic [LW-1:0]           cache_line_r, cache_line_s;
    logic [31:0]             data_lsb_r,   data_lsb_s;

    logic                    stall_s;
    logic [CW-1:0]           cnt_inc_s;
    logic [OFF_W-1:0]        idx_s;
    logic [LW-1:0]           line_ins_s;

    // IO write stall, evaluated against the address currently on the bus.
    always_comb begin
        stall_s = mem_wr_r && (mem_a_r[17:16] == 2'b11) && io_buffer_full;
    end

    // Assembly register with the byte returning this cycle merged in; in READ
    // the byte returning now belongs to the address driven one cycle earlier.
    always_comb begin
        cnt_inc_s  = cnt_r + CW'(1);
        idx_s      = cnt_r[OFF_W-1:0] - OFF_W'(1);
        line_ins_s = line_r;
        line_ins_s[{idx_s, 3'b000} +: 8] = mem_din;
    end

    // Next-state and next-register logic for the transfer FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        len_s        = len_r;
        base_s       = base_r;
        lsb_own_s    = lsb_own_r;
        wdata_s      = wdata_r;
        line_s       = line_r;
        mem_a_s      = mem_a_r;
        mem_dout_s   = mem_dout_r;
        mem_wr_s     = mem_wr_r;
        ready_if_s   = 1'b0;
        ready_lsb_s  = 1'b0;
        cache_line_s = cache_line_r;
        data_lsb_s   = data_lsb_r;

        case (state_r)
            ST_IDLE: begin
                mem_a_s  = {ADDR_WIDTH{1'b0}};
                mem_wr_s = 1'b0;
                cnt_s    = {CW{1'b0}};
                if (ready_if_r || ready_lsb_r) begin
                    // Requester is dropping valid in this cycle; never re-accept.
                    state_s = ST_IDLE;
                end else if (valid_from_lsb && (is_write_from_lsb || !reset_from_rob_bus)) begin
                    base_s    = addr_from_lsb;
                    len_s     = size_to_len(size_from_lsb);
                    lsb_own_s = 1'b1;
                    wdata_s   = data_from_lsb;
                    line_s    = {LW{1'b0}};
                    mem_a_s   = addr_from_lsb;
                    if (is_write_from_lsb) begin
                        state_s    = ST_WRITE;
                        mem_dout_s = data_from_lsb[7:0];
                        mem_wr_s   = 1'b1;
                    end else begin
                        state_s = ST_READ;
                    end
                end else if (valid_from_inst_fetcher) begin
                    state_s   = ST_READ;
                    base_s    = addr_from_inst_fetcher & LINE_MASK;
                    len_s     = LINE_LEN;
                    lsb_own_s = 1'b0;
                    line_s    = {LW{1'b0}};
                    mem_a_s   = addr_from_inst_fetcher & LINE_MASK;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_READ: begin
                if (lsb_own_r && reset_from_rob_bus) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                    mem_a_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                    // cnt_r == 0 is the cycle the first address is on the bus;
                    // no data has come back yet.
                    if (cnt_r != {CW{1'b0}}) begin
                        line_s = line_ins_s;
                    end else begin
                        line_s = line_r;
                    end
                    if (cnt_inc_s < len_r) begin
                        mem_a_s = addr_plus(base_r, cnt_inc_s);
                    end else begin
                        mem_a_s = {ADDR_WIDTH{1'b0}};
                    end
                    if (cnt_r == len_r) begin
                        state_s = ST_IDLE;
                        cnt_s   = {CW{1'b0}};
                        if (lsb_own_r) begin
                            ready_lsb_s = 1'b1;
                            data_lsb_s  = line_ins_s[31:0];
                        end else begin
                            ready_if_s   = 1'b1;
                            cache_line_s = line_ins_s;
                        end
                    end else begin
                        state_s = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                if (stall_s) begin
                    state_s = ST_WRITE;
                end else if (cnt_r == (len_r - CW'(1))) begin
                    state_s     = ST_IDLE;
                    cnt_s       = {CW{1'b0}};
                    mem_a_s     = {ADDR_WIDTH{1'b0}};
                    mem_wr_s    = 1'b0;
                    ready_lsb_s = 1'b1;
                end else begin
                    cnt_s      = cnt_inc_s;
                    mem_a_s    = addr_plus(base_r, cnt_inc_s);
                    mem_dout_s = word_byte(wdata_r, cnt_inc_s[1:0]);
                end
            end

            default: begin
                state_s  = ST_IDLE;
                cnt_s    = {CW{1'b0}};
                mem_a_s  = {ADDR_WIDTH{1'b0}};
                mem_wr_s = 1'b0;
            end
        endcase
    end

    // State/datapath registers: rst clears, rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            len_r        <= {CW{1'b0}};
            base_r       <= {ADDR_WIDTH{1'b0}};
            lsb_own_r    <= 1'b0;
            wdata_r      <= 32'h0000_0000;
            line_r       <= {LW{1'b0}};
            mem_a_r      <= {ADDR_WIDTH{1'b0}};
            mem_dout_r   <= 8'h00;
            mem_wr_r     <= 1'b0;
            ready_if_r   <= 1'b0;
            ready_lsb_r  <= 1'b0;
            cache_line_r <= {LW{1'b0}};
            data_lsb_r   <= 32'h0000_0000;
        end else if (rdy) begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            len_r        <= len_s;
            base_r       <= base_s;
            lsb_own_r    <= lsb_own_s;
            wdata_r      <= wdata_s;
            line_r       <= line_s;
            mem_a_r      <= mem_a_s;
            mem_dout_r   <= mem_dout_s;
            mem_wr_r     <= mem_wr_s;
            ready_if_r   <= ready_if_s;
            ready_lsb_r  <= ready_lsb_s;
            cache_line_r <= cache_line_s;
            data_lsb_r   <= data_lsb_s;
        end
    end

    assign mem_a                      = mem_a_r;
    assign mem_dout                   = mem_dout_r;
    // The write strobe is masked in the same cycle the IO buffer reports full.
    assign mem_wr                     = mem_wr_r & ~stall_s;
    assign ready_to_inst_fetcher      = ready_if_r;
    assign cache_line_to_inst_fetcher = cache_line_r;
    assign ready_to_lsb               = ready_lsb_r;
    assign data_to_lsb                = data_lsb_r;

endmodule

// File: tb/tb_mem_ctrler.sv
module tb_mem_ctrler;

    localparam int LB = 16;
    localparam int AW = 32;
    localparam logic [127:0] LINE_1000 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic [7:0]      mem_din;
    logic [7:0]      mem_dout;
    logic [AW-1:0]   mem_a;
    logic            mem_wr;
    logic            io_buffer_full;
    logic            valid_from_inst_fetcher;
    logic [AW-1:0]   addr_from_inst_fetcher;
    logic            ready_to_inst_fetcher;
    logic [LB*8-1:0] cache_line_to_inst_fetcher;
    logic            valid_from_lsb;
    logic            is_write_from_lsb;
    logic [AW-1:0]   addr_from_lsb;
    logic [1:0]      size_from_lsb;
    logic [31:0]     data_from_lsb;
    logic            ready_to_lsb;
    logic [31:0]     data_to_lsb;
    logic            reset_from_rob_bus;

    mem_ctrler #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .rdy                        (rdy),
        .mem_din                    (mem_din),
        .mem_dout                   (mem_dout),
        .mem_a                      (mem_a),
        .mem_wr                     (mem_wr),
        .io_buffer_full             (io_buffer_full),
        .valid_from_inst_fetcher    (valid_from_inst_fetcher),
        .addr_from_inst_fetcher     (addr_from_inst_fetcher),
        .ready_to_inst_fetcher      (ready_to_inst_fetcher),
        .cache_line_to_inst_fetcher (cache_line_to_inst_fetcher),
        .valid_from_lsb             (valid_from_lsb),
        .is_write_from_lsb          (is_write_from_lsb),
        .addr_from_lsb              (addr_from_lsb),
        .size_from_lsb              (size_from_lsb),
        .data_from_lsb              (data_from_lsb),
        .ready_to_lsb               (ready_to_lsb),
        .data_to_lsb                (data_to_lsb),
        .reset_from_rob_bus         (reset_from_rob_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        bit           chk;
        int           cyc;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    resp_t lsb_q[$];
    resp_t if_q[$];
    wr_t   wr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lsb_pulses = 0;
    int if_pulses = 0;
    bit lsb_seen = 1'b0;
    bit if_seen = 1'b0;

    logic [7:0] ram [0:262143];

    // Cycle counter: value after edge X is X.
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: one-cycle read latency, writes only when the system is enabled.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[32'h1000 + i] <= 8'(i);
        end else if (mem_wr && rdy) begin
            ram[mem_a[17:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: scoreboard pops on each ready pulse.
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (ready_to_lsb && !lsb_seen) begin
            lsb_pulses++;
            if (lsb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lsb_unexpected_ready actual=1 expected=0 (cyc=%0d)", cyc);
            end else begin
                r = lsb_q.pop_front();
                check("lsb_ready_cycle", 128'(cyc), 128'(r.cyc));
                if (r.chk) check("lsb_data", 128'(data_to_lsb), r.data);
            end
        end
        lsb_seen = ready_to_lsb;
        if (ready_to_inst_fetcher && !if_seen) begin
            if_pulses++;
            if (if_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_unexpected_ready actual=1 expected=0 (cyc=%0d)", cyc);
            end else begin
                r = if_q.pop_front();
                check("if_ready_cycle", 128'(cyc), 128'(r.cyc));
                check("if_line", cache_line_to_inst_fetcher, r.data);
            end
        end
        if_seen = ready_to_inst_fetcher;
        if (mem_wr && rdy) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h expected=none", mem_a);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 128'(mem_a), 128'(w.a));
                check("wr_data", 128'(mem_dout), 128'(w.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lsb();
        int n = 0;
        while (!ready_to_lsb && n < 100) begin
            tick();
            n++;
        end
        check("lsb_ready_timeout", 128'(n >= 100), 128'(0));
        valid_from_lsb = 1'b0;
    endtask

    task automatic wait_if();
        int n = 0;
        while (!ready_to_inst_fetcher && n < 100) begin
            tick();
            n++;
        end
        check("if_ready_timeout", 128'(n >= 100), 128'(0));
        valid_from_inst_fetcher = 1'b0;
    endtask

    task automatic lsb_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
        valid_from_lsb    = 1'b1;
        is_write_from_lsb = wr;
        addr_from_lsb     = a;
        size_from_lsb     = sz;
        data_from_lsb     = d;
    endtask

    task automatic push_writes(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.a = a + 32'(k);
            w.d = d[8*k +: 8];
            wr_q.push_back(w);
        end
    endtask

    task automatic push_resp(input bit to_lsb, input logic [127:0] d, input bit chk, input int c);
        resp_t r;
        r.data = d;
        r.chk  = chk;
        r.cyc  = c;
        if (to_lsb) lsb_q.push_back(r);
        else        if_q.push_back(r);
    endtask

    initial begin
        int e;
        int p;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; reset_from_rob_bus = 1'b0;
        valid_from_inst_fetcher = 1'b0; addr_from_inst_fetcher = 32'h0;
        valid_from_lsb = 1'b0; is_write_from_lsb = 1'b0; addr_from_lsb = 32'h0;
        size_from_lsb = 2'd0; data_from_lsb = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_mem_a", 128'(mem_a), 128'(0));
        check("rst_mem_wr", 128'(mem_wr), 128'(0));
        check("rst_mem_dout", 128'(mem_dout), 128'(0));
        check("rst_ready_if", 128'(ready_to_inst_fetcher), 128'(0));
        check("rst_ready_lsb", 128'(ready_to_lsb), 128'(0));
        check("rst_line", cache_line_to_inst_fetcher, 128'(0));
        check("rst_data_lsb", 128'(data_to_lsb), 128'(0));

        // Line fill from inside the line
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h1004;
        tick(); e = cyc;
        push_resp(1'b0, LINE_1000, 1'b1, e + 17);
        for (int k = 0; k < 16; k++) begin
            check("fill_mem_a", 128'(mem_a), 128'(32'h1000 + 32'(k)));
            tick();
        end
        check("fill_mem_a_after", 128'(mem_a), 128'(0));
        wait_if();
        check("fill_idle_mem_a", 128'(mem_a), 128'(0));
        repeat (3) tick();

        // Word store
        push_writes(32'h2000, 32'hDEADBEEF, 4);
        lsb_req(1'b1, 32'h2000, 2'd2, 32'hDEADBEEF);
        tick(); e = cyc;
        push_resp(1'b1, 128'(0), 1'b0, e + 4);
        wait_lsb();
        tick();
        check("store_ram", 128'({ram[18'h2003], ram[18'h2002], ram[18'h2001], ram[18'h2000]}),
              128'(32'hDEADBEEF));
        repeat (3) tick();

        // Contention: LSB half read wins, fetch follows after an idle cycle
        lsb_req(1'b0, 32'h2002, 2'd1, 32'h0);
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h1008;
        tick(); e = cyc;
        push_resp(1'b1, 128'(32'h0000DEAD), 1'b1, e + 3);
        push_resp(1'b0, LINE_1000, 1'b1, e + 5 + 17);
        wait_lsb();
        wait_if();
        repeat (3) tick();

        // IO write stalled for three cycles
        io_buffer_full = 1'b1;
        push_writes(32'h30000, 32'h41, 1);
        lsb_req(1'b1, 32'h30000, 2'd0, 32'h41);
        tick(); e = cyc;
        push_resp(1'b1, 128'(0), 1'b0, e + 4);
        for (int i = 0; i < 3; i++) begin
            check("io_stall_wr", 128'(mem_wr), 128'(0));
            check("io_stall_a", 128'(mem_a), 128'(32'h30000));
            tick();
        end
        io_buffer_full = 1'b0;
        #1;
        check("io_resume_wr", 128'(mem_wr), 128'(1));
        wait_lsb();
        repeat (3) tick();

        // Flush during 2nd byte of a word load
        lsb_req(1'b0, 32'h1000, 2'd2, 32'h0);
        tick(); e = cyc;
        tick();
        reset_from_rob_bus = 1'b1; valid_from_lsb = 1'b0;
        tick();
        reset_from_rob_bus = 1'b0;
        check("flush_mem_a", 128'(mem_a), 128'(0));
        p = lsb_pulses;
        repeat (6) tick();
        check("flush_no_ready", 128'(lsb_pulses), 128'(p));

        // Flush during a fill: fill still completes
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h100C;
        tick(); e = cyc;
        push_resp(1'b0, LINE_1000, 1'b1, e + 17);
        repeat (4) tick();
        reset_from_rob_bus = 1'b1;
        tick();
        reset_from_rob_bus = 1'b0;
        wait_if();
        repeat (3) tick();

        // rst at byte 7 of a fill
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h1000;
        tick(); e = cyc;
        repeat (7) tick();
        check("rst_fill_byte7", 128'(mem_a), 128'(32'h1007));
        rst = 1'b1; valid_from_inst_fetcher = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_mem_a", 128'(mem_a), 128'(0));
        check("midrst_mem_wr", 128'(mem_wr), 128'(0));
        check("midrst_ready_if", 128'(ready_to_inst_fetcher), 128'(0));
        check("midrst_line", cache_line_to_inst_fetcher, 128'(0));
        p = if_pulses;
        repeat (20) tick();
        check("midrst_no_ready", 128'(if_pulses), 128'(p));

        // rdy low for 5 cycles mid word write
        push_writes(32'h2100, 32'hCAFEF00D, 4);
        lsb_req(1'b1, 32'h2100, 2'd2, 32'hCAFEF00D);
        tick(); e = cyc;
        push_resp(1'b1, 128'(0), 1'b0, e + 4 + 5);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("freeze_mem_a", 128'(mem_a), 128'(32'h2101));
            check("freeze_mem_wr", 128'(mem_wr), 128'(1));
            tick();
        end
        rdy = 1'b1;
        wait_lsb();
        tick();
        check("freeze_ram", 128'({ram[18'h2103], ram[18'h2102], ram[18'h2101], ram[18'h2100]}),
              128'(32'hCAFEF00D));
        repeat (3) tick();

        check("lsb_q_drained", 128'(lsb_q.size()), 128'(0));
        check("if_q_drained", 128'(if_q.size()), 128'(0));
        check("wr_q_drained", 128'(wr_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
